// File: rtl/mem_access_pkg.sv
// Shared types and constants for the byte-serial data-memory access unit.
package mem_access_pkg;

    localparam int BEAT_W         = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_TAIL,
        WR,
        DONE
    } state_t;

    // Little-endian byte lane of a 32-bit word (lane 0 = bits 7:0).
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [BEAT_W-1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and byte-memory bus of the access unit.
// master: the access unit itself; slave: pipeline plus byte memory.
interface mem_access_unit_if
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
);
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    // Pipeline side
    logic              MemRead_i;
    logic              MemWrite_i;
    logic [ADDR_W-1:0] addr_i;
    logic [WORD_W-1:0] data_i;
    logic [WORD_W-1:0] data_o;
    logic              stall_o;
    logic              err_o;

    // Byte memory side
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_o;
    logic              mem_we_o;
    logic              mem_re_o;
    logic [7:0]        mem_data_i;

    modport master (
        input  MemRead_i, MemWrite_i, addr_i, data_i, mem_data_i,
        output data_o, stall_o, err_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o
    );

    modport slave (
        output MemRead_i, MemWrite_i, addr_i, data_i, mem_data_i,
        input  data_o, stall_o, err_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o
    );

endinterface

// File: rtl/mem_access_unit.sv
// Splits one 32-bit load/store into four little-endian byte transactions,
// stalling the pipeline until the word is complete. Misaligned or
// out-of-range word addresses are rejected without any memory strobe.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_access_unit_if.master  bus
);

    localparam logic [ADDR_W-1:0] MAX_BASE  = ADDR_W'(MEM_BYTES - BYTES_PER_WORD);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTES_PER_WORD - 1);

    state_t              state_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         data_reg;
    logic                err_o_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [7:0]          mem_data_reg;
    logic                mem_we_reg;
    logic                mem_re_reg;

    logic                request;
    logic                reject;
    logic [BEAT_W-1:0]   beat_inc;
    logic                stall;

    assign request  = bus.MemRead_i | bus.MemWrite_i;
    assign reject   = (bus.addr_i[1:0] != 2'b00) || (bus.addr_i > MAX_BASE);
    assign beat_inc = beat_reg + BEAT_W'(1);

    // Lanes 0..2 of a load: each byte arrives one cycle after its strobe,
    // so lane gi is captured while the RD beat counter reads gi+1.
    // Lane 3 is taken straight from the bus in RD_TAIL.
    for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
        logic [7:0] byte_reg;

        // Capture the returned byte for this lane
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                byte_reg <= '0;
            end else if (state_reg == RD && beat_reg == BEAT_W'(gi + 1)) begin
                byte_reg <= bus.mem_data_i;
            end
        end
    end

    // Main FSM: sequencing, beat counter and registered memory/result outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            beat_reg     <= '0;
            base_reg     <= '0;
            wdata_reg    <= '0;
            data_reg     <= '0;
            err_o_reg    <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_we_reg   <= 1'b0;
            mem_re_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (request) begin
                        base_reg  <= bus.addr_i;
                        wdata_reg <= bus.data_i;
                        beat_reg  <= '0;
                        if (reject) begin
                            state_reg <= DONE;
                            err_o_reg <= 1'b1;
                        end else if (bus.MemWrite_i) begin
                            // A store wins when both requests are raised
                            state_reg    <= WR;
                            mem_we_reg   <= 1'b1;
                            mem_addr_reg <= bus.addr_i;
                            mem_data_reg <= byte_lane(bus.data_i, '0);
                        end else begin
                            state_reg    <= RD;
                            mem_re_reg   <= 1'b1;
                            mem_addr_reg <= bus.addr_i;
                        end
                    end
                end

                WR: begin
                    if (beat_reg == LAST_BEAT) begin
                        state_reg    <= DONE;
                        mem_we_reg   <= 1'b0;
                        mem_data_reg <= '0;
                    end else begin
                        beat_reg     <= beat_inc;
                        mem_addr_reg <= base_reg + ADDR_W'(beat_inc);
                        mem_data_reg <= byte_lane(wdata_reg, beat_inc);
                    end
                end

                RD: begin
                    if (beat_reg == LAST_BEAT) begin
                        state_reg  <= RD_TAIL;
                        mem_re_reg <= 1'b0;
                    end else begin
                        beat_reg     <= beat_inc;
                        mem_addr_reg <= base_reg + ADDR_W'(beat_inc);
                    end
                end

                RD_TAIL: begin
                    data_reg  <= {bus.mem_data_i, g_lane[2].byte_reg,
                                  g_lane[1].byte_reg, g_lane[0].byte_reg};
                    state_reg <= DONE;
                end

                DONE: begin
                    err_o_reg <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Pipeline freeze: follows the request in IDLE, released in DONE
    always_comb begin
        stall = 1'b1;
        case (state_reg)
            IDLE:    stall = request;
            DONE:    stall = 1'b0;
            default: stall = 1'b1;
        endcase
    end

    assign bus.stall_o    = stall;
    assign bus.data_o     = data_reg;
    assign bus.err_o      = err_o_reg;
    assign bus.mem_addr_o = mem_addr_reg;
    assign bus.mem_data_o = mem_data_reg;
    assign bus.mem_we_o   = mem_we_reg;
    assign bus.mem_re_o   = mem_re_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected byte
// writes, read addresses and per-access responses; a negedge monitor pops
// and compares whenever the DUT strobes memory or completes an access.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .MEM_BYTES (32),
        .ADDR_W    (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Byte memory model with one-cycle read latency
    logic [7:0] mem [0:31];
    logic [7:0] rdata_reg = 8'h00;

    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o[4:0]] <= bus.mem_data_o;
        if (bus.mem_re_o) rdata_reg <= mem[bus.mem_addr_o[4:0]];
    end
    assign bus.mem_data_i = rdata_reg;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_beat_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [7:0]  stall;
    } resp_t;

    wr_beat_t    wr_q[$];
    logic [31:0] rd_q[$];
    resp_t       resp_q[$];

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_data = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare strobes and completions against the queues
    initial begin
        wr_beat_t wb;
        resp_t    rs;
        logic [31:0] ra;
        int       stall_cnt;
        logic     prev_stall;
        stall_cnt  = 0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt  = 0;
                prev_stall = 1'b0;
            end else begin
                if (bus.mem_we_o) begin
                    if (wr_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_write: addr %0d data %h, none expected",
                                 bus.mem_addr_o, bus.mem_data_o);
                    end else begin
                        wb = wr_q.pop_front();
                        check32("wr_addr", bus.mem_addr_o, wb.addr);
                        check32("wr_data", {24'h0, bus.mem_data_o}, {24'h0, wb.data});
                        $display("[TB] write addr %0d data %h", bus.mem_addr_o, bus.mem_data_o);
                    end
                end
                if (bus.mem_re_o) begin
                    if (rd_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_read: addr %0d, none expected", bus.mem_addr_o);
                    end else begin
                        ra = rd_q.pop_front();
                        check32("rd_addr", bus.mem_addr_o, ra);
                        $display("[TB] read  addr %0d", bus.mem_addr_o);
                    end
                end
                if (bus.stall_o) begin
                    stall_cnt++;
                end else if (prev_stall) begin
                    if (resp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: err %0b data %h", bus.err_o, bus.data_o);
                    end else begin
                        rs = resp_q.pop_front();
                        check32("done_err", {31'h0, bus.err_o}, {31'h0, rs.err});
                        check32("done_data", bus.data_o, rs.data);
                        check32("stall_cycles", stall_cnt, {24'h0, rs.stall});
                        $display("[TB] done  err %0b data %h stall %0d", bus.err_o, bus.data_o, stall_cnt);
                    end
                    stall_cnt = 0;
                end else if (bus.err_o) begin
                    tests++; fails++;
                    $display("FAIL stray_err: got 1, expected 0 outside DONE");
                end
                prev_stall = bus.stall_o;
            end
        end
    end

    // Issue one access; word is store data or the expected load result
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] word, input logic exp_err, input logic [7:0] exp_stall);
        resp_t r;
        logic  done;
        if (!exp_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr) wr_q.push_back({addr + 32'(i), word[8*i +: 8]});
                else    rd_q.push_back(addr + 32'(i));
            end
            if (!wr) model_data = word;
        end
        r.err   = exp_err;
        r.data  = model_data;
        r.stall = exp_stall;
        resp_q.push_back(r);

        @(posedge clk); #1;
        bus.MemRead_i  = rd;
        bus.MemWrite_i = wr;
        bus.addr_i     = addr;
        bus.data_i     = word;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!bus.stall_o) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: stall still 1 after 20 cycles, expected release");
        end
        #1;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        bus.addr_i     = 32'h0;
        bus.data_i     = 32'h0;

        // Reset state
        #12;
        check32("rst_data_o",   bus.data_o, 32'h0);
        check32("rst_err_o",    {31'h0, bus.err_o}, 32'h0);
        check32("rst_we",       {31'h0, bus.mem_we_o}, 32'h0);
        check32("rst_re",       {31'h0, bus.mem_re_o}, 32'h0);
        check32("rst_mem_addr", bus.mem_addr_o, 32'h0);
        check32("rst_mem_data", {24'h0, bus.mem_data_o}, 32'h0);
        check32("rst_stall",    {31'h0, bus.stall_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_req(1'b0, 1'b1, 32'd8,  32'hDEADBEEF, 1'b0, 8'd5);  // store
        do_req(1'b1, 1'b0, 32'd8,  32'hDEADBEEF, 1'b0, 8'd6);  // load back
        do_req(1'b1, 1'b0, 32'd6,  32'h0,        1'b1, 8'd1);  // misaligned load
        do_req(1'b0, 1'b1, 32'd32, 32'hCAFEF00D, 1'b1, 8'd1);  // out-of-range store
        do_req(1'b1, 1'b0, 32'd29, 32'h0,        1'b1, 8'd1);  // misaligned and past end
        do_req(1'b1, 1'b1, 32'd0,  32'h11223344, 1'b0, 8'd5);  // both: store wins
        do_req(1'b1, 1'b0, 32'd28, 32'h00000000, 1'b0, 8'd6);  // last valid word

        // Reset in the beat-2 cycle of a load
        for (int i = 0; i < 4; i++) rd_q.push_back(32'(i));
        @(posedge clk); #1;
        bus.MemRead_i = 1'b1;
        bus.addr_i    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check32("beat2_re",   {31'h0, bus.mem_re_o}, 32'h1);
        check32("beat2_addr", bus.mem_addr_o, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check32("arst_re",     {31'h0, bus.mem_re_o}, 32'h0);
        check32("arst_data_o", bus.data_o, 32'h0);
        check32("arst_we",     {31'h0, bus.mem_we_o}, 32'h0);
        $display("[TB] async reset mid-load re %0b data %h", bus.mem_re_o, bus.data_o);
        bus.MemRead_i = 1'b0;
        rd_q.delete();
        model_data = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_req(1'b1, 1'b0, 32'd0, 32'h11223344, 1'b0, 8'd6);  // load after reset
        do_req(1'b1, 1'b0, 32'd3, 32'h0,        1'b1, 8'd1);  // rejected, data held

        repeat (3) @(posedge clk);
        check32("wr_q_empty",   wr_q.size(), 32'd0);
        check32("rd_q_empty",   rd_q.size(), 32'd0);
        check32("resp_q_empty", resp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
